// File: rtl/prim_pad_pkg.sv
// Shared pad definitions: filter configuration type, default counter width
// and the bypass decode used by the input conditioner.
package prim_pad_pkg;

    localparam int unsigned PadCntWidth = 4;

    typedef struct packed {
        logic                   en;
        logic [PadCntWidth-1:0] thresh;
    } filter_cfg_t;

    // A zero threshold behaves exactly like a disabled filter.
    function automatic logic filter_is_bypass(input logic en, input logic thresh_is_zero);
        return (~en) | thresh_is_zero;
    endfunction

endpackage

// File: rtl/prim_pad_sync.sv
// Multi-flop synchroniser for an asynchronous pad input; reset value is
// a parameter so the chain agrees with the downstream idle level.
module prim_pad_sync #(
    parameter int unsigned SyncStages = 2,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] r_chain;

    // Shift the pad level through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chain <= {SyncStages{ResetVal}};
        end else begin
            r_chain <= {r_chain[SyncStages-2:0], d_i};
        end
    end

    assign q_o = r_chain[SyncStages-1];

endmodule

// File: rtl/prim_pad_input_conditioner.sv
// Pad receive path: synchronise, glitch-filter with a programmable stability
// count, then report single-cycle edge pulses and sticky edge status.
module prim_pad_input_conditioner
    import prim_pad_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntWidth   = PadCntWidth,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pad_in_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] filter_thresh_i,
    input  logic                status_clr_i,
    output logic                in_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                rise_sticky_o,
    output logic                fall_sticky_o
);

    logic                w_sync;
    logic                w_bypass;
    logic [CntWidth-1:0] w_thresh_m1;
    logic                w_filt_d;
    logic [CntWidth-1:0] w_cnt_d;
    logic                w_rise;
    logic                w_fall;

    logic                r_filt;
    logic                r_prev;
    logic [CntWidth-1:0] r_cnt;
    logic                r_rise_sticky;
    logic                r_fall_sticky;

    prim_pad_sync #(
        .SyncStages (SyncStages),
        .ResetVal   (ResetVal)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pad_in_i),
        .q_o    (w_sync)
    );

    assign w_bypass    = filter_is_bypass(filter_en_i, (filter_thresh_i == '0));
    assign w_thresh_m1 = filter_thresh_i - CntWidth'(1);

    // Filter next state; '>=' lets a lowered threshold commit at once instead of wrapping.
    always_comb begin
        w_filt_d = r_filt;
        w_cnt_d  = r_cnt;
        if (w_bypass) begin
            w_filt_d = w_sync;
            w_cnt_d  = '0;
        end else if (w_sync == r_filt) begin
            w_cnt_d  = '0;
        end else if (r_cnt >= w_thresh_m1) begin
            w_filt_d = w_sync;
            w_cnt_d  = '0;
        end else begin
            w_cnt_d  = r_cnt + CntWidth'(1);
        end
    end

    // Filtered level, its one-cycle-old copy and the stability counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_filt <= ResetVal;
            r_prev <= ResetVal;
            r_cnt  <= '0;
        end else begin
            r_filt <= w_filt_d;
            r_prev <= r_filt;
            r_cnt  <= w_cnt_d;
        end
    end

    assign w_rise = r_filt & ~r_prev;
    assign w_fall = ~r_filt & r_prev;

    // Sticky status: a new edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rise_sticky <= 1'b0;
            r_fall_sticky <= 1'b0;
        end else begin
            r_rise_sticky <= w_rise | (r_rise_sticky & ~status_clr_i);
            r_fall_sticky <= w_fall | (r_fall_sticky & ~status_clr_i);
        end
    end

    assign in_o          = r_filt;
    assign rise_o        = w_rise;
    assign fall_o        = w_fall;
    assign rise_sticky_o = r_rise_sticky;
    assign fall_sticky_o = r_fall_sticky;

endmodule

// File: tb/tb_prim_pad_input_conditioner.sv
// Randomised bench with a run-length reference model plus directed
// literal checks of latency, glitch rejection, sticky and reset behaviour.
module tb_prim_pad_input_conditioner;

    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pad = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] thr = '0;
    logic          clr = 1'b0;
    logic          in_o, rise_o, fall_o, rs_o, fs_o;

    logic          pad1 = 1'b1;
    logic          en1 = 1'b0;
    logic [CW-1:0] thr1 = '0;
    logic          clr1 = 1'b0;
    logic          in1, rise1, fall1, rs1, fs1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prim_pad_input_conditioner #(.SyncStages(SYNC), .CntWidth(CW), .ResetVal(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad), .filter_en_i(en),
        .filter_thresh_i(thr), .status_clr_i(clr), .in_o(in_o), .rise_o(rise_o),
        .fall_o(fall_o), .rise_sticky_o(rs_o), .fall_sticky_o(fs_o));

    prim_pad_input_conditioner #(.SyncStages(SYNC), .CntWidth(CW), .ResetVal(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad1), .filter_en_i(en1),
        .filter_thresh_i(thr1), .status_clr_i(clr1), .in_o(in1), .rise_o(rise1),
        .fall_o(fall1), .rise_sticky_o(rs1), .fall_sticky_o(fs1));

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: filtered level changes once the delayed pad has
    // disagreed with it for T consecutive cycles.
    bit m_pipe[$];
    bit m_filt, m_prev, m_rs, m_fs;
    int m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
            m_filt = 1'b0; m_prev = 1'b0; m_run = 0; m_rs = 1'b0; m_fs = 1'b0;
        end else begin
            bit s;
            s = m_pipe.pop_front();
            m_pipe.push_back(pad);
            m_rs = (m_filt && !m_prev) || (m_rs && !clr);
            m_fs = (!m_filt && m_prev) || (m_fs && !clr);
            m_prev = m_filt;
            if (!en || thr == 0) begin
                m_filt = s; m_run = 0;
            end else if (s == m_filt) begin
                m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run >= int'(thr)) begin m_filt = s; m_run = 0; end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #2;
        chk("model_in",  in_o,   m_filt);
        chk("model_rise", rise_o, m_filt & ~m_prev);
        chk("model_fall", fall_o, ~m_filt & m_prev);
        chk("model_rs",  rs_o,   m_rs);
        chk("model_fs",  fs_o,   m_fs);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // 1: reset state for both reset values
        pad = 1'b0; en = 1'b0; thr = '0; clr = 1'b0;
        step(2);
        chk("rst_in0", in_o, 1'b0);
        chk("rst_rise0", rise_o, 1'b0);
        chk("rst_rs0", rs_o, 1'b0);
        chk("rst_fs0", fs_o, 1'b0);
        chk("rst_in1", in1, 1'b1);
        rst_n = 1'b1;
        step(3);
        chk("rel_in1", in1, 1'b1);
        chk("rel_fall1", fall1, 1'b0);
        chk("rel_fs1", fs1, 1'b0);

        // 2: bypass latency and sticky clear
        do_reset();
        pad = 1'b1;
        step(2);
        chk("byp_in_e2", in_o, 1'b0);
        step(1);
        chk("byp_in_e3", in_o, 1'b1);
        chk("byp_rise", rise_o, 1'b1);
        step(1);
        chk("byp_rise_end", rise_o, 1'b0);
        chk("byp_rs", rs_o, 1'b1);
        clr = 1'b1;
        step(1);
        chk("byp_rs_clr", rs_o, 1'b0);
        clr = 1'b0;

        // 3: glitch shorter than threshold rejected, long pulse accepted
        pad = 1'b0; en = 1'b1; thr = CW'(4);
        do_reset();
        pad = 1'b1; step(3);
        pad = 1'b0; step(10);
        chk("glitch_in", in_o, 1'b0);
        chk("glitch_rs", rs_o, 1'b0);
        pad = 1'b1; step(5);
        chk("flt_in_e5", in_o, 1'b0);
        step(1);
        chk("flt_in_e6", in_o, 1'b1);
        chk("flt_rise", rise_o, 1'b1);

        // 4: lowered threshold mid-count, then max threshold
        pad = 1'b0; thr = CW'(10);
        do_reset();
        pad = 1'b1; step(9);
        chk("thr10_cnt7", in_o, 1'b0);
        thr = CW'(3); step(1);
        chk("thr_lower", in_o, 1'b1);
        thr = CW'(15); pad = 1'b0; step(16);
        chk("thr15_e16", in_o, 1'b1);
        step(1);
        chk("thr15_e17", in_o, 1'b0);
        chk("thr15_fall", fall_o, 1'b1);

        // 5: clear coincident with fall keeps sticky, clear alone drops it
        clr = 1'b1; step(1);
        chk("clr_set_wins", fs_o, 1'b1);
        step(1);
        chk("clr_alone", fs_o, 1'b0);
        clr = 1'b0;

        // 6: reset mid-count with pad toggling
        thr = CW'(8); pad = 1'b1; step(6);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in0", in_o, 1'b0);
        chk("midrst_in1", in1, 1'b1);
        for (int i = 0; i < 4; i++) begin pad = ~pad; step(1); end
        pad = 1'b1;
        rst_n = 1'b1;
        step(1);
        chk("midrst_rel_in", in_o, 1'b0);
        chk("midrst_rel_rise", rise_o, 1'b0);
        chk("midrst_rel_fall1", fall1, 1'b0);

        // Random phase: pulses of random length under changing configuration
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                en  = ($urandom_range(0, 3) != 0);
                thr = CW'($urandom_range(0, 15));
            end
            pad = $urandom_range(0, 1);
            for (int k = 0, len = $urandom_range(1, 18); k < len; k++) begin
                clr = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 40) == 0) thr = CW'($urandom_range(1, 15));
                step(1);
            end
            if ($urandom_range(0, 60) == 0) do_reset();
        end
        clr = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
